// File: rtl/wb_vram_slave.sv
// Wishbone frame-buffer slave backed by synchronous block RAM.
// Handles classic cycles and CTI/BTE registered-feedback bursts.
module wb_vram_slave #(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [29:0] wbs_addr_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  output logic        wbs_ack_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIC,
    BURST
  } state_t;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_t      state_q, state_d;
  addr_t       addr_q, addr_d;
  addr_t       rd_addr;
  logic        ack_q, ack_d;
  logic        rd_en;
  logic        wr_en;
  logic        req;
  logic        bypass;
  logic [31:0] data_q;
  logic [31:0] mem [DEPTH];
  logic        unused_addr;

  assign unused_addr = ^wbs_addr_i[29:ADDR_WIDTH];

  assign req = wbs_cyc_i & wbs_stb_i;

  // ack_q is only ever high in CLASSIC or BURST, so it qualifies the write
  assign wr_en  = ack_q & req & wbs_we_i;
  assign bypass = wr_en & (rd_addr == addr_q);

  function automatic addr_t next_addr(
    input addr_t      a,
    input logic [2:0] cti,
    input logic [1:0] bte
  );
    addr_t n;
    n = a;
    if (cti == 3'b010) begin
      unique case (bte)
        2'b00:   n = a + addr_t'(1);
        2'b01:   n[1:0] = a[1:0] + 2'd1;
        2'b10:   n[2:0] = a[2:0] + 3'd1;
        default: n[3:0] = a[3:0] + 4'd1;
      endcase
    end
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = wbs_addr_i[ADDR_WIDTH-1:0];
          rd_addr = addr_d;
          rd_en   = 1'b1;
          ack_d   = 1'b1;
          if (wbs_cti_i == 3'b001 ||
              wbs_cti_i == 3'b010)
            state_d = BURST;
          else
            state_d = CLASSIC;
        end
      end
      CLASSIC: begin
        state_d = IDLE;
      end
      BURST: begin
        if (req && wbs_cti_i != 3'b111) begin
          addr_d  = next_addr(addr_q,
                              wbs_cti_i,
                              wbs_bte_i);
          rd_addr = addr_d;
          rd_en   = 1'b1;
          ack_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b])
          mem[addr_q][8*b +: 8] <= wbs_data_i[8*b +: 8];
      end
    end
  end

  // Write-first: a prefetch of the word being written sees the new bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bypass && wbs_sel_i[b])
          data_q[8*b +: 8] <= wbs_data_i[8*b +: 8];
        else
          data_q[8*b +: 8] <= mem[rd_addr][8*b +: 8];
      end
    end
  end

  assign wbs_data_o = data_q;
  assign wbs_ack_o  = ack_q;

endmodule
